// File: rtl/mem_block_copier.sv
// Word-granular DMA engine for the single-port data memory: block copy (overlap-safe) or constant fill.
// Memory-side outputs decode from registered state and pointers only; start never reaches mem_* combinationally.
module mem_block_copier #(
    parameter int DEPTH = 100,
    parameter int LW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [31:0]   src,
    input  logic [31:0]   dst,
    input  logic [LW-1:0] len,
    input  logic [31:0]   fill_val,
    input  logic [31:0]   mem_RD,
    output logic [31:0]   mem_A,
    output logic [31:0]   mem_WD,
    output logic          mem_WE,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [LW-1:0] words_done
);

    // state   | meaning
    // S_IDLE  | waiting for start; command inputs latched on start
    // S_CHECK | range test and direction/pointer setup
    // S_READ  | copy only: present src_ptr, capture mem_RD into buffer
    // S_WRITE | present dst_ptr with buffer or fill value, write enabled
    // S_DONE  | one-cycle done pulse, back to idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_mode;
    logic          r_desc;
    logic          r_err;
    logic [31:0]   r_src;
    logic [31:0]   r_dst;
    logic [31:0]   r_fill;
    logic [31:0]   r_src_ptr;
    logic [31:0]   r_dst_ptr;
    logic [31:0]   r_buf;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_words_done;

    logic [32:0]   w_src_end;
    logic [32:0]   w_dst_end;
    logic          w_range_err;
    logic          w_desc;
    logic          w_last;

    // 33-bit sums so an address near 2^32 cannot wrap past the range test
    assign w_src_end   = {1'b0, r_src} + {{(33-LW){1'b0}}, r_len};
    assign w_dst_end   = {1'b0, r_dst} + {{(33-LW){1'b0}}, r_len};
    assign w_range_err = (w_dst_end > 33'(DEPTH)) || (!r_mode && (w_src_end > 33'(DEPTH)));
    assign w_desc      = !r_mode && (r_src < r_dst) && ({1'b0, r_dst} < w_src_end);
    assign w_last      = (r_words_done + LW'(1)) == r_len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        mem_A  = 32'h0;
        mem_WD = 32'h0;
        mem_WE = 1'b0;
        busy   = (r_state != S_IDLE);
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_range_err || (r_len == '0)) w_next = S_DONE;
                else if (r_mode)                  w_next = S_WRITE;
                else                              w_next = S_READ;
            end
            S_READ: begin
                mem_A  = r_src_ptr;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_A  = r_dst_ptr;
                mem_WD = r_mode ? r_fill : r_buf;
                mem_WE = 1'b1;
                if (w_last)      w_next = S_DONE;
                else if (r_mode) w_next = S_WRITE;
                else             w_next = S_READ;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode       <= 1'b0;
            r_desc       <= 1'b0;
            r_err        <= 1'b0;
            r_src        <= 32'h0;
            r_dst        <= 32'h0;
            r_fill       <= 32'h0;
            r_src_ptr    <= 32'h0;
            r_dst_ptr    <= 32'h0;
            r_buf        <= 32'h0;
            r_len        <= '0;
            r_words_done <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode       <= mode;
                        r_src        <= src;
                        r_dst        <= dst;
                        r_len        <= len;
                        r_fill       <= fill_val;
                        r_err        <= 1'b0;
                        r_words_done <= '0;
                    end
                end
                S_CHECK: begin
                    r_err     <= w_range_err;
                    r_desc    <= w_desc;
                    r_src_ptr <= w_desc ? (w_src_end[31:0] - 32'd1) : r_src;
                    r_dst_ptr <= w_desc ? (w_dst_end[31:0] - 32'd1) : r_dst;
                end
                S_READ: begin
                    r_buf     <= mem_RD;
                    r_src_ptr <= r_desc ? (r_src_ptr - 32'd1) : (r_src_ptr + 32'd1);
                end
                S_WRITE: begin
                    r_dst_ptr    <= r_desc ? (r_dst_ptr - 32'd1) : (r_dst_ptr + 32'd1);
                    r_words_done <= r_words_done + LW'(1);
                end
                default: ;
            endcase
        end
    end

    assign err        = r_err;
    assign words_done = r_words_done;

endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier: table of commands checked against a reference memory and a write scoreboard,
// plus hand sequences for reset during a fill.
module tb_mem_block_copier;

    localparam int DEPTH = 100;
    localparam int LW    = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [LW-1:0] len;
    logic [31:0]   fill_val;
    logic [31:0]   mem_RD;
    logic [31:0]   mem_A;
    logic [31:0]   mem_WD;
    logic          mem_WE;
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] words_done;

    mem_block_copier #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .fill_val   (fill_val),
        .mem_RD     (mem_RD),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done)
    );

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    assign mem_RD = (mem_A < 32'(DEPTH)) ? mem[mem_A[6:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_WE && (mem_A < 32'(DEPTH))) mem[mem_A[6:0]] <= mem_WD;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          mode;
        logic [31:0]   src;
        logic [31:0]   dst;
        logic [LW-1:0] len;
        logic [31:0]   fill;
        logic          exp_err;
        int            exp_done;
        logic [LW-1:0] exp_words;
        bit            poke;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    vec_t vecs [12];
    wr_t  sb [$];
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic mem_check(input string name);
        int nbad;
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk(name, 64'(nbad), 64'd0);
    endtask

    // Expected writes in issue order; the reference memory gets the final block contents.
    task automatic push_model(input vec_t v);
        logic [31:0] snap [0:DEPTH-1];
        int n, s, d;
        bit desc;
        if (v.exp_err || v.len == '0) return;
        n = int'(v.len);
        s = int'(v.src);
        d = int'(v.dst);
        if (v.mode) begin
            for (int i = 0; i < n; i++) begin
                sb.push_back('{a: 32'(d + i), d: v.fill});
                ref_mem[d + i] = v.fill;
            end
        end else begin
            for (int i = 0; i < n; i++) snap[i] = ref_mem[s + i];
            desc = (s < d) && (d < s + n);
            for (int j = 0; j < n; j++) begin
                int i;
                i = desc ? (n - 1 - j) : j;
                sb.push_back('{a: 32'(d + i), d: snap[i]});
            end
            for (int i = 0; i < n; i++) ref_mem[d + i] = snap[i];
        end
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int done_at, we_bad, busy_bad, n;
        bit exp_we;
        wr_t w;
        push_model(v);
        n = int'(v.len);
        @(negedge clk);
        start = 1'b1; mode = v.mode; src = v.src; dst = v.dst; len = v.len; fill_val = v.fill;
        @(posedge clk);
        #1;
        start = 1'b0; mode = ~v.mode; src = 32'h55; dst = 32'h3; len = 16'd9; fill_val = 32'hDEAD_BEEF;
        done_at = 0; we_bad = 0; busy_bad = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (v.poke && k == 3) begin
                start = 1'b1; mode = 1'b1; dst = 32'd80; len = 16'd5; fill_val = 32'h0BAD_0BAD;
            end
            if (v.poke && k == 4) start = 1'b0;
            if (!busy) busy_bad++;
            if (v.exp_err || n == 0)  exp_we = 1'b0;
            else if (v.mode)          exp_we = (k >= 2) && (k <= n + 1);
            else                      exp_we = (k >= 2) && (k <= 2 * n + 1) && (k % 2 == 1);
            if (mem_WE !== exp_we) we_bad++;
            if (mem_WE === 1'b1) begin
                if (sb.size() == 0) begin
                    chk({tag, "_unexpected_write_addr"}, 64'(mem_A), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    w = sb.pop_front();
                    chk({tag, "_write"}, {mem_A, mem_WD}, {w.a, w.d});
                end
            end
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
        end
        chk({tag, "_done_cycle"}, 64'(done_at), 64'(v.exp_done));
        chk({tag, "_err"}, 64'(err), 64'(v.exp_err));
        chk({tag, "_words_done"}, 64'(words_done), 64'(v.exp_words));
        chk({tag, "_busy_during"}, 64'(busy_bad), 64'd0);
        chk({tag, "_we_pattern"}, 64'(we_bad), 64'd0);
        chk({tag, "_done_outputs_idle"}, {mem_A, mem_WD}, 64'd0);
        chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
        sb.delete();
        mem_check({tag, "_mem"});
        @(negedge clk);
        chk({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int wes;
        vec_t v;
        checks = 0; failures = 0;
        reset = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'hC0DE_0000 + 32'(i * 7);
            ref_mem[i] = 32'hC0DE_0000 + 32'(i * 7);
        end
        for (int i = 0; i < 5; i++) begin mem[i] = 32'(i + 1); ref_mem[i] = 32'(i + 1); end
        for (int i = 0; i < 4; i++) begin mem[20 + i] = 32'(7 + i); ref_mem[20 + i] = 32'(7 + i); end

        //          mode  src            dst            len     fill           err   done words poke
        vecs[0]  = '{1'b1, 32'd0,         32'd10,        16'd4,  32'hA5A5_0001, 1'b0, 6,   16'd4, 0};
        vecs[1]  = '{1'b0, 32'd0,         32'd50,        16'd5,  32'h0,         1'b0, 12,  16'd5, 0};
        vecs[2]  = '{1'b0, 32'd20,        32'd22,        16'd4,  32'h0,         1'b0, 10,  16'd4, 0};
        vecs[3]  = '{1'b1, 32'd0,         32'd98,        16'd3,  32'h1234_5678, 1'b1, 2,   16'd0, 0};
        vecs[4]  = '{1'b1, 32'd0,         32'd5,         16'd0,  32'h1111_1111, 1'b0, 2,   16'd0, 0};
        vecs[5]  = '{1'b0, 32'd60,        32'd58,        16'd6,  32'h0,         1'b0, 14,  16'd6, 0};
        vecs[6]  = '{1'b0, 32'd30,        32'd30,        16'd3,  32'h0,         1'b0, 8,   16'd3, 0};
        vecs[7]  = '{1'b0, 32'd97,        32'd0,         16'd4,  32'h0,         1'b1, 2,   16'd0, 0};
        vecs[8]  = '{1'b1, 32'd0,         32'd96,        16'd4,  32'h7777_0000, 1'b0, 6,   16'd4, 0};
        vecs[9]  = '{1'b1, 32'd0,         32'hFFFF_FFFF, 16'd2,  32'h2222_2222, 1'b1, 2,   16'd0, 0};
        vecs[10] = '{1'b0, 32'd0,         32'd70,        16'd3,  32'h0,         1'b0, 8,   16'd3, 1};
        vecs[11] = '{1'b0, 32'hFFFF_FFF0, 32'd0,         16'h20, 32'h0,         1'b1, 2,   16'd0, 0};

        #1;
        chk("reset_outputs", {mem_A, mem_WD}, 64'd0);
        chk("reset_flags", {47'd0, mem_WE, busy, done, err, words_done}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {62'd0, busy, done}, 64'd0);

        for (int i = 0; i < 12; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted during the third write of an 8-word fill: only the first two words land.
        ref_mem[40] = 32'hFEED_0040;
        ref_mem[41] = 32'hFEED_0040;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; dst = 32'd40; len = 16'd8; fill_val = 32'hFEED_0040;
        @(posedge clk);
        #1;
        start = 1'b0;
        wes = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (mem_WE === 1'b1) wes++;
        end
        chk("rst_mid_we_cycles", 64'(wes), 64'd3);
        reset = 1'b0;
        #1;
        chk("rst_mid_outputs", {mem_A, mem_WD}, 64'd0);
        chk("rst_mid_flags", {47'd0, mem_WE, busy, done, err, words_done}, 64'd0);
        repeat (2) @(negedge clk);
        chk("rst_mid_no_done", {62'd0, busy, done}, 64'd0);
        reset = 1'b1;
        mem_check("rst_mid_mem");

        v = '{1'b1, 32'd0, 32'd40, 16'd8, 32'h600D_0001, 1'b0, 10, 16'd8, 0};
        run_cmd(v, "post_reset_fill");
        v = '{1'b0, 32'd40, 32'd85, 16'd8, 32'h0, 1'b0, 18, 16'd8, 0};
        run_cmd(v, "post_reset_copy");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_block_copier.md
# mem_block_copier

Word-granular DMA engine that sits on the CPU's data-memory port and moves or initializes blocks of data memory without processor involvement. It drives the memory's address, write-data and write-enable inputs and consumes its combinational read-data output, acting as the initiator for the single-port data memory (combinational read, write on the rising clock edge). Two modes are supported: copy (source block to destination block, overlap-safe) and fill (constant into destination block). The top level muxes its memory-side outputs against the CPU's port while busy is high.

## Interface
- DEPTH, 100: number of 32-bit words in the data memory; valid word addresses are 0..DEPTH-1
- LW, 16: width of the length and progress fields
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  command strobe; sampled only in IDLE
- mode  input  1  0 = copy, 1 = fill
- src  input  32  source word address (copy only)
- dst  input  32  destination word address
- len  input  LW  number of words to transfer
- fill_val  input  32  word written in fill mode
- mem_RD  input  32  read data from memory (combinational from mem_A)
- mem_A  output  32  memory word address
- mem_WD  output  32  memory write data
- mem_WE  output  1  memory write enable, active high
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  range error flag for the last accepted command
- words_done  output  LW  count of words written by the current or last command

## Operation
- States: IDLE, CHECK, READ, WRITE, DONE.
- IDLE: start=1 latches src, dst, len, mode and fill_val; clears err and words_done; goes to CHECK. While not IDLE, start and all command inputs are ignored.
- CHECK (1 cycle): range test at 33-bit width, so wrap-around is impossible. The test is dst+len > DEPTH, or in copy mode src+len > DEPTH.
  - Range error: err set, go to DONE; no memory writes.
  - len==0: go to DONE with err=0.
  - Otherwise, copy mode goes to READ and fill mode goes to WRITE.
- Direction: descending when copy and src < dst < src+len. Both pointers then start at src+len-1 and dst+len-1 and decrement. In all other cases pointers start at src and dst and increment. src==dst copies normally, with every word rewritten to itself.
- READ: mem_A=src_ptr, mem_WE=0. On the clock edge, mem_RD is captured into the data buffer, src_ptr steps, and the state moves to WRITE.
- WRITE: mem_A=dst_ptr, mem_WE=1, mem_WD = buffer (copy) or fill_val (fill). On the clock edge, dst_ptr steps and words_done increments.
  - If words_done+1 == len, go to DONE.
  - Else copy mode goes to READ and fill mode stays in WRITE.
- DONE (1 cycle): done=1, then return to IDLE. err and words_done hold until the next accepted start.
- In IDLE, CHECK and DONE: mem_WE=0, mem_A=0, mem_WD=0.
- All memory-side outputs and flags decode from registered state and pointers. There is no combinational path from start to mem_*.

## Timing
- Reset values (asserted asynchronously, immediately): state IDLE, mem_A=0, mem_WD=0, mem_WE=0, busy=0, done=0, err=0, words_done=0. The buffer and pointers also clear to 0.
- Reset mid-transfer aborts immediately and no done pulse is issued. Memory keeps every word already written; the engine does not undo them.
- If start is accepted at edge E, busy rises after E:
  - copy of N≥1 words: CHECK, then 2N cycles of READ/WRITE, then DONE; done is high in cycle 2N+2 after E.
  - fill of N words: done is high in cycle N+2.
  - error or len==0: done is high in cycle 2.
- busy falls on the edge ending DONE. A start held high in that same cycle is accepted at the next edge, so the engine sees at most one idle cycle between back-to-back commands.
- Write cadence: one write per 2 cycles in copy mode, one write per cycle in fill mode.

## Test plan
- Fill: mode=1, dst=10, len=4, fill_val=32'hA5A5_0001. Required: words 10..13 hold the value; words 9 and 14 are unchanged; done is high in cycle 6 after start; words_done=4; err=0.
- Forward copy: words 0..4 = 1..5; copy src=0, dst=50, len=5. Required: words 50..54 = 1..5; mem_WE alternates 0/1 for 10 cycles; done is high in cycle 12.
- Overlap descending: words 20..23 = 7,8,9,10; copy src=20, dst=22, len=4. Required: words 22..25 = 7,8,9,10; the first write is to address 25.
- Range error: fill dst=98, len=3. Required: err=1, no cycle with mem_WE=1, done is high in cycle 2, words_done=0. Separately, len=0 gives done in cycle 2 with err=0.
- Start while busy: pulse start with different operands during a copy. Required: the pulse is ignored and the original transfer completes unchanged.
- Reset mid-op: assert reset low during the third WRITE of a len=8 fill. Required: all outputs return to reset values immediately; exactly 2 words were written; a new command after release runs correctly.
